keycode_input_ctrl: RTL and testbench

- Downstream consumer of the SoC's keyboard keycode PIO (8-bit) and the two board push-buttons (key0/key1).
- Converts the level-valued keycode into one-cycle press, release and auto-repeat events for the game logic (blade/cursor control, menu).
- Debounces both push-buttons and produces single-cycle press pulses.
- All logic runs on the system clock.

---
 rtl/keycode_input_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_keycode_input_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/keycode_input_ctrl.sv
// Keyboard keycode event generator (press/release/repeat) plus debounced
// single-cycle press pulses for the two board push-buttons.

module keycode_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          pressed;
  logic          level;
  logic [DW-1:0] deb_cnt;

  // Synchronizer flops reset to the released (high) level so reset never
  // looks like a press.
  assign level = ~sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      pressed <= 1'b0;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (level == pressed) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        pressed <= level;
        deb_cnt <= '0;
        press   <= level;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end
endmodule

module keycode_input_ctrl #(
  parameter int STABLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] keycode_export,
  input  logic       key0_n,
  input  logic       key1_n,
  output logic       event_valid,
  output logic [1:0] event_type,
  output logic [7:0] event_code,
  output logic [7:0] held_code,
  output logic       btn0_press,
  output logic       btn1_press,
  output logic [2:0] state_dbg
);
  localparam int SW   = $clog2(STABLE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_REPEAT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESS   = 3'd1,
    S_HOLD    = 3'd2,
    S_RELEASE = 3'd3,
    S_SWAP    = 3'd4
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [7:0]    kc_q;
  logic [SW-1:0] stab_cnt;
  logic [RW-1:0] rpt_cnt;
  logic [7:0]    pend_code;
  logic          accept;
  logic          rpt_zero;
  logic          ev_valid_d;
  logic [1:0]    ev_type_d;
  logic [7:0]    ev_code_d;
  logic [7:0]    held_d;

  assign accept    = (stab_cnt == SW'(STABLE_CYCLES)) && (kc_q != held_code);
  assign rpt_zero  = (rpt_cnt == '0);
  assign state_dbg = state;

  // Keycode filter: a value must be seen unchanged for STABLE_CYCLES samples.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      kc_q     <= 8'h00;
      stab_cnt <= '0;
    end else begin
      kc_q <= keycode_export;
      if (keycode_export != kc_q)
        stab_cnt <= '0;
      else if (stab_cnt != SW'(STABLE_CYCLES))
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= S_IDLE;
    else                state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (accept) state_d = S_PRESS;
      S_PRESS:   state_d = S_HOLD;
      S_HOLD:    if (accept) state_d = (kc_q == 8'h00) ? S_RELEASE : S_SWAP;
      S_RELEASE: state_d = S_IDLE;
      S_SWAP:    state_d = S_PRESS;
      default:   state_d = S_IDLE;
    endcase
  end

  // Events are computed from the transition and registered alongside the
  // state, so a press is visible in the same cycle the FSM sits in PRESS.
  always_comb begin
    ev_valid_d = 1'b0;
    ev_type_d  = EV_PRESS;
    ev_code_d  = 8'h00;
    held_d     = held_code;
    case (state)
      S_IDLE: begin
        if (accept) begin
          ev_valid_d = 1'b1;
          ev_code_d  = kc_q;
          held_d     = kc_q;
        end
      end
      S_HOLD: begin
        if (accept) begin
          ev_valid_d = 1'b1;
          ev_type_d  = EV_RELEASE;
          ev_code_d  = held_code;
          if (kc_q == 8'h00) held_d = 8'h00;
        end else if (rpt_zero) begin
          ev_valid_d = 1'b1;
          ev_type_d  = EV_REPEAT;
          ev_code_d  = held_code;
        end
      end
      S_SWAP: begin
        ev_valid_d = 1'b1;
        ev_code_d  = pend_code;
        held_d     = pend_code;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      event_valid <= 1'b0;
      event_type  <= 2'b00;
      event_code  <= 8'h00;
      held_code   <= 8'h00;
      pend_code   <= 8'h00;
      rpt_cnt     <= '0;
    end else begin
      event_valid <= ev_valid_d;
      event_type  <= ev_type_d;
      event_code  <= ev_code_d;
      held_code   <= held_d;
      if (state == S_HOLD && accept)
        pend_code <= kc_q;
      if (state_d == S_PRESS)
        rpt_cnt <= RW'(REPEAT_DELAY - 1);
      else if (state == S_HOLD)
        rpt_cnt <= rpt_zero ? RW'(REPEAT_RATE - 1) : rpt_cnt - 1'b1;
      else if (state == S_PRESS)
        rpt_cnt <= rpt_zero ? rpt_cnt : rpt_cnt - 1'b1;
      else
        rpt_cnt <= '0;
    end
  end

  keycode_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn0 (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .key_n (key0_n),
    .press (btn0_press)
  );

  keycode_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .key_n (key1_n),
    .press (btn1_press)
  );
endmodule

// File: tb/tb_keycode_input_ctrl.sv
// Bench for keycode_input_ctrl: directed keycode/button stimulus, expected
// events (with their cycle of arrival) queued and checked by a monitor.

module tb_keycode_input_ctrl;
  localparam int W = 44;
  localparam logic [1:0] T_PRESS = 2'b00, T_RELEASE = 2'b01, T_REPEAT = 2'b10;
  localparam logic [1:0] SRC_KEY = 2'd0, SRC_BTN0 = 2'd1, SRC_BTN1 = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       key0_n = 1'b1;
  logic       key1_n = 1'b1;
  logic       event_valid;
  logic [1:0] event_type;
  logic [7:0] event_code;
  logic [7:0] held_code;
  logic       btn0_press;
  logic       btn1_press;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  keycode_input_ctrl #(
    .STABLE_CYCLES(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .keycode_export(keycode),
    .key0_n(key0_n), .key1_n(key1_n), .event_valid(event_valid),
    .event_type(event_type), .event_code(event_code), .held_code(held_code),
    .btn0_press(btn0_press), .btn1_press(btn1_press), .state_dbg(state_dbg)
  );

  // Clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input int c, input logic [1:0] src,
                                      input logic [1:0] typ, input logic [7:0] code);
    return {32'(c), src, typ, code};
  endfunction

  task automatic sb_pop(input logic [W-1:0] obs);
    logic [W-1:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_out: got cyc=%0d src=%0d type=%0d code=%02h, none expected",
               obs[43:12], obs[11:10], obs[9:8], obs[7:0]);
    end else begin
      exp = exp_q.pop_front();
      if (obs !== exp) begin
        n_err++;
        $display("FAIL event: got cyc=%0d src=%0d type=%0d code=%02h, need cyc=%0d src=%0d type=%0d code=%02h",
                 obs[43:12], obs[11:10], obs[9:8], obs[7:0],
                 exp[43:12], exp[11:10], exp[9:8], exp[7:0]);
      end
    end
  endtask

  // Monitor: samples on the falling edge, one pop per presented output.
  always @(negedge clk) begin
    if (event_valid) sb_pop(mk(cyc, SRC_KEY, event_type, event_code));
    if (btn0_press)  sb_pop(mk(cyc, SRC_BTN0, 2'b00, 8'h00));
    if (btn1_press)  sb_pop(mk(cyc, SRC_BTN1, 2'b00, 8'h00));
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, need %0h", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic goto(input int target);
    while (cyc < target) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_kc(input logic [7:0] v, output int t);
    @(posedge clk); #1;
    keycode = v;
    t = cyc;
  endtask

  task automatic set_key0(input logic v, output int t);
    @(posedge clk); #1;
    key0_n = v;
    t = cyc;
  endtask

  task automatic set_key1(input logic v, output int t);
    @(posedge clk); #1;
    key1_n = v;
    t = cyc;
  endtask

  initial begin
    int t, t2, t3, b, r, w;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_event_valid", 32'(event_valid), 0);
    check("rst_held_code", 32'(held_code), 0);
    check("rst_btn0", 32'(btn0_press), 0);
    check("rst_btn1", 32'(btn1_press), 0);
    check("rst_state", 32'(state_dbg), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    goto(cyc + 8);

    // Press 0x1A, repeats at +10 then every 3, release after 20 cycles
    set_kc(8'h1A, t);
    exp_q.push_back(mk(t + 6, SRC_KEY, T_PRESS, 8'h1A));
    for (int rc = t + 16; rc < t + 26; rc += 3)
      exp_q.push_back(mk(rc, SRC_KEY, T_REPEAT, 8'h1A));
    goto(t + 7);
    check("held_after_press", 32'(held_code), 32'h1A);
    goto(t + 19);
    set_kc(8'h00, t2);
    exp_q.push_back(mk(t2 + 6, SRC_KEY, T_RELEASE, 8'h1A));
    goto(t2 + 8);
    check("held_after_release", 32'(held_code), 0);
    goto(t2 + 20);

    // Swap 0x1A -> 0x07: release then press on the next cycle
    set_kc(8'h1A, t);
    exp_q.push_back(mk(t + 6, SRC_KEY, T_PRESS, 8'h1A));
    goto(t + 7);
    set_kc(8'h07, t2);
    exp_q.push_back(mk(t2 + 6, SRC_KEY, T_RELEASE, 8'h1A));
    exp_q.push_back(mk(t2 + 7, SRC_KEY, T_PRESS, 8'h07));
    for (int rc = t2 + 17; rc < t2 + 25; rc += 3)
      exp_q.push_back(mk(rc, SRC_KEY, T_REPEAT, 8'h07));
    goto(t2 + 8);
    check("held_after_swap", 32'(held_code), 32'h07);
    goto(t2 + 18);
    set_kc(8'h00, t3);
    exp_q.push_back(mk(t3 + 6, SRC_KEY, T_RELEASE, 8'h07));
    goto(t3 + 10);
    check("held_after_swap_release", 32'(held_code), 0);

    // Two-cycle glitch: no event
    set_kc(8'h1A, t);
    goto(t + 1);
    set_kc(8'h00, t2);
    goto(t2 + 15);
    check("held_after_glitch", 32'(held_code), 0);
    check("state_after_glitch", 32'(state_dbg), 0);

    // key0 bounce then a solid press; release gives no pulse
    set_key0(1'b0, b);
    goto(b + 1); set_key0(1'b1, w);
    goto(b + 3); set_key0(1'b0, w);
    goto(b + 5); set_key0(1'b1, w);
    goto(b + 7); set_key0(1'b0, t);
    exp_q.push_back(mk(t + 6, SRC_BTN0, 2'b00, 8'h00));
    goto(t + 9); set_key0(1'b1, w);
    goto(w + 15);

    // key1 clean press
    set_key1(1'b0, t);
    exp_q.push_back(mk(t + 6, SRC_BTN1, 2'b00, 8'h00));
    goto(t + 7); set_key1(1'b1, w);
    goto(w + 15);

    // Reset while in HOLD, key still held afterwards gives a fresh press
    set_kc(8'h1A, t);
    exp_q.push_back(mk(t + 6, SRC_KEY, T_PRESS, 8'h1A));
    goto(t + 10);
    check("hold_before_reset", 32'(held_code), 32'h1A);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_held", 32'(held_code), 0);
    check("async_rst_state", 32'(state_dbg), 0);
    check("async_rst_valid", 32'(event_valid), 0);
    goto(cyc + 3);
    @(posedge clk); #1 rst_n = 1'b1;
    r = cyc;
    exp_q.push_back(mk(r + 6, SRC_KEY, T_PRESS, 8'h1A));
    goto(r + 8);
    check("held_after_reset_press", 32'(held_code), 32'h1A);
    set_kc(8'h00, t2);
    exp_q.push_back(mk(t2 + 6, SRC_KEY, T_RELEASE, 8'h1A));
    goto(t2 + 10);

    // Drain: every queued expectation must have been seen
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    while (exp_q.size() != 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_out: got nothing, need cyc=%0d src=%0d type=%0d code=%02h",
               e[43:12], e[11:10], e[9:8], e[7:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
